// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register of the pipelined CPU. It captures the MEM-stage
// result, selects ALU result or load data for write-back, and drives the
// register-file write port. The hazard unit can stall (hold) or flush
// (insert a bubble) the stage. A saturating counter tracks retired
// instructions for debug.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset
//   stall_i        hold current stage contents
//   flush_i        squash incoming instruction (bubble); overrides stall_i
//   valid_i        MEM slot holds a real instruction
//   RegWrite_i     instruction writes a register
//   MemtoReg_i     1 = write back load data, 0 = ALU result
//   RDaddr_i       destination register
//   ALUres_i       ALU result from MEM stage
//   MemData_i      load data from data memory
//   valid_o        WB slot holds a real instruction
//   RegWrite_o     register-file write enable
//   RDaddr_o       register-file write address
//   RDdata_o       register-file write data (also the forwarding source)
//   retire_cnt_o   saturating count of instructions that entered WB
//
// Valid semantics: there is no backpressure toward MEM. valid_i qualifies the
// incoming slot on every non-stalled, non-flushed edge; valid_o qualifies the
// WB slot for the whole cycle. RegWrite_o is only ever asserted together with
// valid_o. All outputs come straight from registers (no input-to-output path).
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 32,
  parameter int SUPPRESS_R0 = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [DATA_W-1:0] MemData_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic              r_valid;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [DATA_W-1:0] r_alures;
  logic [DATA_W-1:0] r_memdata;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_cnt_sat;
  logic              w_rd_ok;

  assign w_cnt_sat = &r_retire_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_rdaddr     <= '0;
      r_alures     <= '0;
      r_memdata    <= '0;
      r_retire_cnt <= '0;
    end else if (flush_i) begin
      // Bubble: only the control bits are cleared; address/data are left
      // alone because they are meaningless while RegWrite_o is low.
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!stall_i) begin
      r_valid    <= valid_i;
      // An invalid slot must never write, whatever RegWrite_i says.
      r_regwrite <= valid_i & RegWrite_i;
      r_memtoreg <= MemtoReg_i;
      r_rdaddr   <= RDaddr_i;
      r_alures   <= ALUres_i;
      r_memdata  <= MemData_i;
      if (valid_i && !w_cnt_sat) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  // r0 is hard-wired zero in the register file; optionally never request it.
  assign w_rd_ok = (SUPPRESS_R0 == 0) || (r_rdaddr != '0);

  assign valid_o      = r_valid;
  assign RegWrite_o   = r_valid & r_regwrite & w_rd_ok;
  assign RDaddr_o     = r_rdaddr;
  assign RDdata_o     = r_memtoreg ? r_memdata : r_alures;
  assign retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Two instances share one stimulus stream: dut (defaults: 32-bit counter,
// r0 suppressed) and dut_b (4-bit counter, r0 not suppressed). The driver
// applies inputs on the falling edge and pushes the expected post-edge view
// of the WB slot into exp_q; the monitor pops one entry shortly after every
// rising edge and compares.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] ALUres_i;
  logic [31:0] MemData_i;

  logic        valid_o,    valid_o_b;
  logic        RegWrite_o, RegWrite_o_b;
  logic [4:0]  RDaddr_o,   RDaddr_o_b;
  logic [31:0] RDdata_o,   RDdata_o_b;
  logic [31:0] retire_cnt_o;
  logic [3:0]  retire_cnt_o_b;

  mem_wb_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .RDaddr_i(RDaddr_i), .ALUres_i(ALUres_i), .MemData_i(MemData_i),
    .valid_o(valid_o), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o),
    .RDdata_o(RDdata_o), .retire_cnt_o(retire_cnt_o)
  );

  mem_wb_stage #(.CNT_W(4), .SUPPRESS_R0(0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .RDaddr_i(RDaddr_i), .ALUres_i(ALUres_i), .MemData_i(MemData_i),
    .valid_o(valid_o_b), .RegWrite_o(RegWrite_o_b), .RDaddr_o(RDaddr_o_b),
    .RDdata_o(RDdata_o_b), .retire_cnt_o(retire_cnt_o_b)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        valid;
    logic        we;
    logic        we_b;
    logic        chk;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: the WB slot seen as "the instruction that last entered"
  // with its already-selected write-back value.
  logic        m_valid, m_we, m_chk;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  longint      m_cnt;
  int          m_cnt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_rd = 0; m_data = 0; m_chk = 1;
    m_cnt = 0; m_cnt_b = 0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic valid, input logic we, input logic m2r,
                      input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] mem);
    exp_t e;
    @(negedge clk_i);
    rst_i = rst; stall_i = stall; flush_i = flush; valid_i = valid;
    RegWrite_i = we; MemtoReg_i = m2r; RDaddr_i = rd;
    ALUres_i = alu; MemData_i = mem;
    if (rst) begin
      model_reset();
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_chk = 0;
    end else if (!stall) begin
      m_valid = valid;
      m_we    = we;
      m_rd    = rd;
      m_data  = m2r ? mem : alu;
      m_chk   = 1;
      if (valid) begin
        m_cnt   = (m_cnt   + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        m_cnt_b = (m_cnt_b + 1 > 15) ? 15 : m_cnt_b + 1;
      end
    end
    e.valid = m_valid;
    e.we_b  = m_valid & m_we;
    e.we    = m_valid & m_we & (m_rd != 0);
    e.chk   = m_chk | m_valid;
    e.rd    = m_rd;
    e.data  = m_data;
    e.cnt   = m_cnt[31:0];
    e.cnt_b = m_cnt_b[3:0];
    exp_q.push_back(e);
  endtask

  task automatic cap(input logic valid, input logic we, input logic m2r,
                     input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
    step(1'b0, 1'b0, 1'b0, valid, we, m2r, rd, alu, mem);
  endtask

  // Asynchronous reset raised between edges; outputs must clear at once.
  task automatic async_reset_pulse();
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_rst_cnt_b", 64'(retire_cnt_o_b), 64'd0);
    check("async_rst_cnt", 64'(retire_cnt_o), 64'd0);
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_we", 64'(RegWrite_o_b), 64'd0);
    check("async_rst_data", 64'(RDdata_o), 64'd0);
    model_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_o",      64'(valid_o),        64'(e.valid));
        check("valid_o_b",    64'(valid_o_b),      64'(e.valid));
        check("RegWrite_o",   64'(RegWrite_o),     64'(e.we));
        check("RegWrite_o_b", 64'(RegWrite_o_b),   64'(e.we_b));
        check("retire_cnt",   64'(retire_cnt_o),   64'(e.cnt));
        check("retire_cnt_b", 64'(retire_cnt_o_b), 64'(e.cnt_b));
        if (e.chk) begin
          check("RDaddr_o",   64'(RDaddr_o),   64'(e.rd));
          check("RDdata_o",   64'(RDdata_o),   64'(e.data));
          check("RDaddr_o_b", 64'(RDaddr_o_b), 64'(e.rd));
          check("RDdata_o_b", 64'(RDdata_o_b), 64'(e.data));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; stall_i = 0; flush_i = 0; valid_i = 0; RegWrite_i = 0;
    MemtoReg_i = 0; RDaddr_i = 0; ALUres_i = 0; MemData_i = 0;
    model_reset();

    // Reset held with a live instruction on the inputs, then released.
    step(1, 0, 0, 1, 1, 0, 5'd5, 32'h1111, 32'h2222);
    step(1, 0, 0, 1, 1, 0, 5'd5, 32'h1111, 32'h2222);
    cap(1, 1, 0, 5'd5, 32'h1111, 32'h2222);

    // Write-back mux.
    cap(1, 1, 0, 5'd3, 32'h1234, 32'hABCD);
    cap(1, 1, 1, 5'd3, 32'h1234, 32'hABCD);

    // r0: suppressed on dut, written on dut_b, still counted.
    cap(1, 1, 0, 5'd0, 32'h9999, 32'h0);
    // Valid instruction that does not write.
    cap(1, 0, 0, 5'd9, 32'h7777, 32'h0);
    // Invalid slot asking to write.
    cap(0, 1, 0, 5'd4, 32'h4444, 32'h0);

    // Stall holds instruction A for three cycles, then release.
    cap(1, 1, 0, 5'd7, 32'h55, 32'h0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 1, 1, 5'd12 + 5'(i), 32'hDEAD_0000 + i, 32'hBEEF_0000 + i);
    cap(1, 1, 1, 5'd10, 32'h0, 32'hCAFE);

    // Flush wins over stall.
    step(0, 1, 1, 1, 1, 0, 5'd11, 32'h1, 32'h2);
    step(0, 0, 1, 1, 1, 0, 5'd11, 32'h1, 32'h2);

    // Saturate the 4-bit counter, then async reset mid-cycle.
    for (int i = 0; i < 20; i++)
      cap(1, 1, 0, 5'(i + 1), $urandom, $urandom);
    async_reset_pulse();
    cap(1, 1, 0, 5'd6, 32'h600D, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, s, f, v, w, m;
      logic [4:0] rd;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 5) == 0);
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 3) != 0);
      m  = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step(r, s, f, v, w, m, rd, $urandom, $urandom);
    end

    repeat (3) @(negedge clk_i);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
